// File: rtl/geofence_driver.sv
// -----------------------------------------------------------------------------
// geofence_driver
//
// Drives the geofence core from a pattern ROM and scores its replies.
// Each object is six ROM words; word k=0 also carries the expected is_inside
// in bit 31. The block fills a six-entry tuple buffer, bursts the six tuples
// onto X/Y/R on consecutive cycles, then waits for the core's one-cycle valid
// strobe. While waiting, it refills the buffer with the next object so that
// the next burst can start in the cycle right after a reply.
//
// Handshake: valid is a single-cycle strobe from the core. No ready exists.
// A strobe is accepted only in WAIT, and only once the next object's buffer
// is full (or no objects remain). A strobe in FILL or SEND is flagged and
// dropped. An early strobe in WAIT is flagged and ends the run.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rom_addr / rom_data   pattern ROM, 1-cycle read latency
//                         rom_data = {exp, X[9:0], Y[9:0], R[10:0]}
//   dut_reset             reset held on the geofence core until the first
//                         buffer is full
//   X, Y, R               receiver tuple; zero outside SEND
//   valid, is_inside      geofence result strobe and value
//   pass_cnt, fail_cnt    saturating score counters
//   done, timeout_err,
//   proto_err             sticky status flags
//   fsm_state             current state (FILL=0, SEND=1, WAIT=2, DONE=3)
// -----------------------------------------------------------------------------
module geofence_driver #(
   parameter int NUM_OBJ = 8,
   parameter int AW      = 8,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   output logic [AW-1:0] rom_addr,
   input  logic [31:0]   rom_data,
   output logic          dut_reset,
   output logic [9:0]    X,
   output logic [9:0]    Y,
   output logic [10:0]   R,
   input  logic          valid,
   input  logic          is_inside,
   output logic [7:0]    pass_cnt,
   output logic [7:0]    fail_cnt,
   output logic          done,
   output logic          timeout_err,
   output logic          proto_err,
   output logic [1:0]    fsm_state
);

   localparam int          TW        = $clog2(TIMEOUT + 1);
   localparam logic [7:0]  NUM_OBJ_W = 8'(NUM_OBJ);
   localparam logic [TW-1:0] TMO_W   = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_FILL = 2'd0,
      S_SEND = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state;
   logic [30:0]   tbuf [6];
   logic          exp_next;
   logic          exp_cur;
   logic          issue_on;     // a ROM read is being issued this cycle
   logic [2:0]    issue_idx;    // entry index of the read being issued
   logic          rd_pend;      // rom_data holds a word to capture this cycle
   logic [2:0]    rd_idx;       // entry index of that word
   logic          buf_full;
   logic [2:0]    send_idx;     // next tuple to drive; 6 means burst finished
   logic [7:0]    obj_sent;
   logic [TW-1:0] wait_cnt;     // WAIT cycles elapsed, counting the current one

   logic more_obj;
   logic cap_last;

   assign more_obj  = (obj_sent < NUM_OBJ_W);
   assign cap_last  = rd_pend && (rd_idx == 3'd5);
   assign fsm_state = state;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_FILL;
         rom_addr    <= '0;
         dut_reset   <= 1'b1;
         X           <= '0;
         Y           <= '0;
         R           <= '0;
         pass_cnt    <= '0;
         fail_cnt    <= '0;
         done        <= 1'b0;
         timeout_err <= 1'b0;
         proto_err   <= 1'b0;
         for (int i = 0; i < 6; i++) tbuf[i] <= '0;
         exp_next    <= 1'b0;
         exp_cur     <= 1'b0;
         issue_on    <= 1'b1;   // the initial fill starts in cycle 0
         issue_idx   <= '0;
         rd_pend     <= 1'b0;
         rd_idx      <= '0;
         buf_full    <= 1'b0;
         send_idx    <= '0;
         obj_sent    <= '0;
         wait_cnt    <= '0;
      end else begin
         // ROM read issue. The address is not advanced after the sixth read
         // so it never runs past the last entry of the last object; the
         // step to the next object's base happens when the refill starts.
         rd_pend <= 1'b0;
         if (issue_on) begin
            rd_pend <= 1'b1;
            rd_idx  <= issue_idx;
            if (issue_idx == 3'd5) begin
               issue_on <= 1'b0;
            end else begin
               issue_idx <= issue_idx + 3'd1;
               rom_addr  <= rom_addr + AW'(1);
            end
         end

         // Capture: the word read last cycle is on rom_data now.
         if (rd_pend) begin
            tbuf[rd_idx] <= rom_data[30:0];
            if (rd_idx == 3'd0) exp_next <= rom_data[31];
            if (rd_idx == 3'd5) buf_full <= 1'b1;
         end

         case (state)
            S_FILL: begin
               if (valid) proto_err <= 1'b1;
               // tbuf[0] is already stable when the last word is captured,
               // so the burst can start on the same edge.
               if (cap_last) begin
                  state         <= S_SEND;
                  dut_reset     <= 1'b0;
                  {X, Y, R}     <= tbuf[0];
                  send_idx      <= 3'd1;
                  exp_cur       <= exp_next;
                  obj_sent      <= obj_sent + 8'd1;
                  buf_full      <= 1'b0;
               end
            end

            S_SEND: begin
               if (valid) proto_err <= 1'b1;
               if (send_idx == 3'd6) begin
                  {X, Y, R} <= '0;
                  state     <= S_WAIT;
                  wait_cnt  <= TW'(1);
                  if (more_obj) begin
                     issue_on  <= 1'b1;
                     issue_idx <= '0;
                     rom_addr  <= rom_addr + AW'(1);
                  end
               end else begin
                  {X, Y, R} <= tbuf[send_idx];
                  send_idx  <= send_idx + 3'd1;
               end
            end

            S_WAIT: begin
               if (valid) begin
                  if (more_obj && !buf_full) begin
                     proto_err <= 1'b1;
                     state     <= S_DONE;
                     done      <= 1'b1;
                     issue_on  <= 1'b0;
                  end else begin
                     if (is_inside == exp_cur) begin
                        if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
                     end else begin
                        if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
                     end
                     if (more_obj) begin
                        state     <= S_SEND;
                        {X, Y, R} <= tbuf[0];
                        send_idx  <= 3'd1;
                        exp_cur   <= exp_next;
                        obj_sent  <= obj_sent + 8'd1;
                        buf_full  <= 1'b0;
                     end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end
                  end
               end else if (wait_cnt == TMO_W) begin
                  timeout_err <= 1'b1;
                  state       <= S_DONE;
                  done        <= 1'b1;
                  issue_on    <= 1'b0;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end

            S_DONE: begin
               // Terminal until reset; outputs already parked at zero.
            end

            default: state <= S_DONE;
         endcase
      end
   end

endmodule

// File: tb/tb_geofence_driver.sv
// -----------------------------------------------------------------------------
// tb_geofence_driver
//
// Two instances share clock and reset: "main" (NUM_OBJ=2, TIMEOUT=20) runs the
// mismatch, timeout, protocol-error and mid-run reset scenarios; "single"
// (NUM_OBJ=1, default TIMEOUT) runs the one-object pass scenario.
// Expected observations are queued with the cycle they are due in; a monitor
// on the falling edge pops and compares them. Cycle 0 is the first cycle after
// reset release.
// -----------------------------------------------------------------------------
module tb_geofence_driver;

   localparam int AW = 8;

   localparam logic [3:0] K_XYR    = 4'd0;
   localparam logic [3:0] K_ADDR   = 4'd1;
   localparam logic [3:0] K_FLAGS  = 4'd2;
   localparam logic [3:0] K_CNT    = 4'd3;
   localparam logic [3:0] K_XYR1   = 4'd4;
   localparam logic [3:0] K_FLAGS1 = 4'd5;
   localparam logic [3:0] K_CNT1   = 4'd6;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int cyc;
   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // ---------------- main instance ----------------
   logic [AW-1:0] rom_addr;
   logic [31:0]   rom_data;
   logic          dut_reset;
   logic [9:0]    x;
   logic [9:0]    y;
   logic [10:0]   r;
   logic          valid;
   logic          is_inside;
   logic [7:0]    pass_cnt;
   logic [7:0]    fail_cnt;
   logic          done;
   logic          timeout_err;
   logic          proto_err;
   logic [1:0]    fsm_state;

   geofence_driver #(.NUM_OBJ(2), .AW(AW), .TIMEOUT(20)) u_main (
      .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_data(rom_data),
      .dut_reset(dut_reset), .X(x), .Y(y), .R(r), .valid(valid),
      .is_inside(is_inside), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
      .done(done), .timeout_err(timeout_err), .proto_err(proto_err),
      .fsm_state(fsm_state)
   );

   // ---------------- single-object instance ----------------
   logic [AW-1:0] rom_addr_1;
   logic [31:0]   rom_data_1;
   logic          dut_reset_1;
   logic [9:0]    x_1;
   logic [9:0]    y_1;
   logic [10:0]   r_1;
   logic          valid_1;
   logic          is_inside_1;
   logic [7:0]    pass_cnt_1;
   logic [7:0]    fail_cnt_1;
   logic          done_1;
   logic          timeout_err_1;
   logic          proto_err_1;
   logic [1:0]    fsm_state_1;

   geofence_driver #(.NUM_OBJ(1), .AW(AW), .TIMEOUT(255)) u_single (
      .clk(clk), .reset(reset), .rom_addr(rom_addr_1), .rom_data(rom_data_1),
      .dut_reset(dut_reset_1), .X(x_1), .Y(y_1), .R(r_1), .valid(valid_1),
      .is_inside(is_inside_1), .pass_cnt(pass_cnt_1), .fail_cnt(fail_cnt_1),
      .done(done_1), .timeout_err(timeout_err_1), .proto_err(proto_err_1),
      .fsm_state(fsm_state_1)
   );

   // ---------------- pattern ROMs (1-cycle latency) ----------------
   logic [31:0] rom  [256];
   logic [31:0] rom1 [256];
   always @(posedge clk) begin
      rom_data   <= rom[rom_addr];
      rom_data_1 <= rom1[rom_addr_1];
   end

   // Tuple k of object n: X=10+k+100n, Y=20+k+100n, R=30+k+100n.
   function automatic logic [30:0] xyr(input int n, input int k);
      logic [9:0]  tx;
      logic [9:0]  ty;
      logic [10:0] tr;
      tx = 10'(10 + k + 100 * n);
      ty = 10'(20 + k + 100 * n);
      tr = 11'(30 + k + 100 * n);
      return {tx, ty, tr};
   endfunction

   // Main ROM: object 0 expects 0, object 1 expects 1. Bit 31 of the
   // non-first entries holds the opposite value so it must be ignored.
   task automatic load_rom();
      logic e;
      for (int i = 0; i < 256; i++) begin
         rom[i]  = 32'hFFFF_FFFF;
         rom1[i] = 32'hFFFF_FFFF;
      end
      for (int n = 0; n < 2; n++) begin
         e = (n == 1);
         for (int k = 0; k < 6; k++)
            rom[6 * n + k] = {(k == 0) ? e : ~e, xyr(n, k)};
      end
      for (int k = 0; k < 6; k++)
         rom1[k] = {(k == 0), xyr(0, k)};
   endtask

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [15:0] cyc;
      logic [3:0]  kind;
      logic [31:0] val;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks;
   int   n_pass;

   task automatic expect_at(input int c, input logic [3:0] kind, input logic [31:0] v);
      exp_t e;
      e.cyc  = 16'(c);
      e.kind = kind;
      e.val  = v;
      exp_q.push_back(e);
   endtask

   function automatic string kind_name(input logic [3:0] kind);
      case (kind)
         K_XYR:    return "xyr";
         K_ADDR:   return "rom_addr";
         K_FLAGS:  return "flags";
         K_CNT:    return "counts";
         K_XYR1:   return "single_xyr";
         K_FLAGS1: return "single_flags";
         K_CNT1:   return "single_counts";
         default:  return "unknown";
      endcase
   endfunction

   function automatic logic [31:0] observe(input logic [3:0] kind);
      case (kind)
         K_XYR:    return {1'b0, x, y, r};
         K_ADDR:   return {24'b0, rom_addr};
         K_FLAGS:  return {28'b0, dut_reset, done, timeout_err, proto_err};
         K_CNT:    return {16'b0, pass_cnt, fail_cnt};
         K_XYR1:   return {1'b0, x_1, y_1, r_1};
         K_FLAGS1: return {28'b0, dut_reset_1, done_1, timeout_err_1, proto_err_1};
         K_CNT1:   return {16'b0, pass_cnt_1, fail_cnt_1};
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) n_pass++;
      else $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, want);
   endtask

   // Monitor: every falling edge, compare all entries due this cycle.
   always @(negedge clk) begin
      if (!reset) begin
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (int'(exp_q[i].cyc) == cyc) begin
               check(kind_name(exp_q[i].kind), observe(exp_q[i].kind), exp_q[i].val);
               exp_q.delete(i);
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic begin_reset();
      reset       = 1'b1;
      valid       = 1'b0;
      is_inside   = 1'b0;
      valid_1     = 1'b0;
      is_inside_1 = 1'b0;
   endtask

   task automatic release_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic run_to(input int c);
      int guard;
      guard = 0;
      while (cyc < c && guard < 1000) begin
         @(posedge clk);
         #1;
         guard++;
      end
   endtask

   // Hold the strobes high for exactly cycle t.
   task automatic pulse(input int t, input logic v0, input logic in0,
                        input logic v1, input logic in1);
      run_to(t);
      valid       = v0;
      is_inside   = in0;
      valid_1     = v1;
      is_inside_1 = in1;
      @(posedge clk);
      #1;
      valid       = 1'b0;
      is_inside   = 1'b0;
      valid_1     = 1'b0;
      is_inside_1 = 1'b0;
   endtask

   task automatic end_test(input int last);
      exp_t e;
      run_to(last + 1);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++;
         $display("FAIL %s never sampled, due cyc=%0d expected=%h",
                  kind_name(e.kind), e.cyc, e.val);
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int guard;
      n_checks = 0;
      n_pass   = 0;
      load_rom();

      // Reset values, fill timing, mismatch then match; single-object pass.
      begin_reset();
      expect_at(0, K_ADDR, 32'd0);
      expect_at(0, K_FLAGS, 32'b1000);
      expect_at(0, K_XYR, 32'd0);
      expect_at(0, K_CNT, 32'd0);
      expect_at(0, K_FLAGS1, 32'b1000);
      for (int c = 1; c < 6; c++) expect_at(c, K_ADDR, 32'(c));
      expect_at(6, K_FLAGS, 32'b1000);
      expect_at(7, K_FLAGS, 32'b0000);
      expect_at(7, K_FLAGS1, 32'b0000);
      for (int k = 0; k < 6; k++) begin
         expect_at(7 + k, K_XYR, {1'b0, xyr(0, k)});
         expect_at(7 + k, K_XYR1, {1'b0, xyr(0, k)});
         expect_at(13 + k, K_ADDR, 32'(6 + k));
         expect_at(21 + k, K_XYR, {1'b0, xyr(1, k)});
      end
      expect_at(13, K_XYR, 32'd0);
      expect_at(13, K_XYR1, 32'd0);
      expect_at(20, K_CNT, 32'd0);
      expect_at(21, K_CNT, 32'h0001);
      expect_at(27, K_XYR, 32'd0);
      expect_at(40, K_FLAGS, 32'b0000);
      expect_at(40, K_FLAGS1, 32'b0000);
      expect_at(41, K_CNT, 32'h0101);
      expect_at(41, K_FLAGS, 32'b0100);
      expect_at(41, K_CNT1, 32'h0100);
      expect_at(41, K_FLAGS1, 32'b0100);
      expect_at(45, K_XYR, 32'd0);
      release_reset();
      pulse(20, 1'b1, 1'b1, 1'b0, 1'b0);
      pulse(40, 1'b1, 1'b1, 1'b1, 1'b1);
      guard = 0;
      while (!done && guard < 20) begin
         @(posedge clk);
         #1;
         guard++;
      end
      check("done_cycle", 32'(cyc), 32'd41);
      end_test(45);

      // No reply ever: timeout after 20 WAIT cycles.
      begin_reset();
      expect_at(0, K_FLAGS, 32'b1000);
      expect_at(32, K_FLAGS, 32'b0000);
      expect_at(33, K_FLAGS, 32'b0110);
      expect_at(33, K_CNT, 32'd0);
      expect_at(34, K_XYR, 32'd0);
      expect_at(40, K_XYR, 32'd0);
      expect_at(40, K_FLAGS, 32'b0110);
      release_reset();
      end_test(40);

      // Strobe during SEND is flagged and dropped; run completes.
      begin_reset();
      expect_at(9, K_FLAGS, 32'b0000);
      expect_at(10, K_FLAGS, 32'b0001);
      expect_at(10, K_CNT, 32'd0);
      for (int k = 3; k < 6; k++) expect_at(7 + k, K_XYR, {1'b0, xyr(0, k)});
      expect_at(23, K_CNT, 32'h0100);
      expect_at(23, K_XYR, {1'b0, xyr(1, 0)});
      expect_at(28, K_XYR, {1'b0, xyr(1, 5)});
      expect_at(36, K_CNT, 32'h0101);
      expect_at(36, K_FLAGS, 32'b0101);
      release_reset();
      pulse(9, 1'b1, 1'b1, 1'b0, 1'b0);
      pulse(22, 1'b1, 1'b0, 1'b0, 1'b0);
      pulse(35, 1'b1, 1'b0, 1'b0, 1'b0);
      end_test(36);

      // Strobe before the refill completes: flagged, run ends unscored.
      begin_reset();
      expect_at(15, K_FLAGS, 32'b0000);
      expect_at(16, K_FLAGS, 32'b0101);
      expect_at(16, K_CNT, 32'd0);
      expect_at(20, K_XYR, 32'd0);
      expect_at(20, K_FLAGS, 32'b0101);
      release_reset();
      pulse(15, 1'b1, 1'b1, 1'b0, 1'b0);
      end_test(20);

      // Reset in the middle of SEND: everything restarts from FILL.
      begin_reset();
      expect_at(8, K_FLAGS, 32'b0000);
      expect_at(9, K_FLAGS, 32'b0001);
      release_reset();
      pulse(8, 1'b1, 1'b0, 1'b0, 1'b0);
      run_to(10);
      begin_reset();
      expect_at(0, K_ADDR, 32'd0);
      expect_at(0, K_FLAGS, 32'b1000);
      expect_at(0, K_CNT, 32'd0);
      expect_at(0, K_XYR, 32'd0);
      expect_at(1, K_ADDR, 32'd1);
      expect_at(7, K_XYR, {1'b0, xyr(0, 0)});
      expect_at(7, K_FLAGS, 32'b0000);
      release_reset();
      end_test(8);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
